// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stage
// Brief    : IF/ID pipeline register with field split and immediate-extension decode.
// Revision : 1.0
// ============================================================================
module if_id_stage #(
    parameter int               DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              instr_valid_in,
    input  logic [DATA_W-1:0] pc_plus4_in,
    input  logic [DATA_W-1:0] instr_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] pc_plus4_out,
    output logic [DATA_W-1:0] instr_out,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [15:0]       imm,
    output logic              arith,
    output logic [25:0]       jump_target
);

    localparam logic [0:0] c_EMPTY = 1'b0;
    localparam logic [0:0] c_FULL  = 1'b1;

    // Logical immediates (andi/ori/xori/lui) zero-extend; everything else sign-extends.
    function automatic logic arith_of(input logic [5:0] op);
        return !(op == 6'h0C || op == 6'h0D || op == 6'h0E || op == 6'h0F);
    endfunction

    localparam logic c_NOP_ARITH = arith_of(NOP_INSTR[31:26]);

    logic [0:0]        r_state;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_pc_plus4;
    logic              r_arith;

    logic [DATA_W-1:0] w_load_instr;
    logic [DATA_W-1:0] w_load_pc;
    logic [0:0]        w_load_state;
    logic              w_load_arith;

    // Bubble path selects constants so an undefined instr_in never reaches state.
    always_comb begin
        w_load_instr = NOP_INSTR;
        w_load_pc    = '0;
        w_load_state = c_EMPTY;
        if (instr_valid_in) begin
            w_load_instr = instr_in;
            w_load_pc    = pc_plus4_in;
            w_load_state = c_FULL;
        end
        w_load_arith = arith_of(w_load_instr[31:26]);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_state    <= c_EMPTY;
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= '0;
            r_arith    <= c_NOP_ARITH;
        end else if (!stall) begin
            r_state    <= w_load_state;
            r_instr    <= w_load_instr;
            r_pc_plus4 <= w_load_pc;
            r_arith    <= w_load_arith;
        end
    end

    assign valid_out    = (r_state == c_FULL);
    assign pc_plus4_out = r_pc_plus4;
    assign instr_out    = r_instr;
    assign arith        = r_arith;
    assign opcode       = r_instr[31:26];
    assign rs           = r_instr[25:21];
    assign rt           = r_instr[20:16];
    assign rd           = r_instr[15:11];
    assign shamt        = r_instr[10:6];
    assign funct        = r_instr[5:0];
    assign imm          = r_instr[15:0];
    assign jump_target  = r_instr[25:0];

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_stage
// Brief    : Directed self-checking bench for if_id_stage.
// Revision : 1.0
// ============================================================================
module tb_if_id_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        instr_valid_in;
    logic [31:0] pc_plus4_in;
    logic [31:0] instr_in;
    logic        valid_out;
    logic [31:0] pc_plus4_out;
    logic [31:0] instr_out;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        arith;
    logic [25:0] jump_target;

    int n_vec;
    int n_err;

    if_id_stage #(
        .DATA_W    (32),
        .NOP_INSTR (32'h00000000)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .instr_valid_in (instr_valid_in),
        .pc_plus4_in    (pc_plus4_in),
        .instr_in       (instr_in),
        .valid_out      (valid_out),
        .pc_plus4_out   (pc_plus4_out),
        .instr_out      (instr_out),
        .opcode         (opcode),
        .rs             (rs),
        .rt             (rt),
        .rd             (rd),
        .shamt          (shamt),
        .funct          (funct),
        .imm            (imm),
        .arith          (arith),
        .jump_target    (jump_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        instr_valid_in = v;
        instr_in       = ins;
        pc_plus4_in    = pc;
    endtask

    // Whole-register check; decoded fields are checked against the MIPS field layout.
    task automatic chk_all(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                           input logic ev, input logic ea);
        chk({tag, ".instr"},  instr_out,    ei);
        chk({tag, ".pc"},     pc_plus4_out, ep);
        chk({tag, ".valid"},  valid_out,    ev);
        chk({tag, ".arith"},  arith,        ea);
        chk({tag, ".opcode"}, opcode,       ei[31:26]);
        chk({tag, ".rs"},     rs,           ei[25:21]);
        chk({tag, ".rt"},     rt,           ei[20:16]);
        chk({tag, ".rd"},     rd,           ei[15:11]);
        chk({tag, ".shamt"},  shamt,        ei[10:6]);
        chk({tag, ".funct"},  funct,        ei[5:0]);
        chk({tag, ".imm"},    imm,          ei[15:0]);
        chk({tag, ".jt"},     jump_target,  ei[25:0]);
        chk({tag, ".noX"},    $isunknown({valid_out, pc_plus4_out, instr_out, arith}), 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 32'h2128FFFF, 32'h00000044);
        step();
        chk_all("reset", 32'h0, 32'h0, 1'b0, 1'b1);

        // addi $t0,$t1,-1
        reset = 1'b0;
        drive(1'b1, 32'h2128FFFF, 32'h00400004);
        step();
        chk("addi.opcode", opcode, 6'h08);
        chk("addi.rs", rs, 5'd9);
        chk("addi.rt", rt, 5'd8);
        chk("addi.imm", imm, 16'hFFFF);
        chk("addi.arith", arith, 1'b1);
        chk("addi.valid", valid_out, 1'b1);
        chk("addi.pc", pc_plus4_out, 32'h00400004);

        // Zero-extending opcodes and their neighbours
        drive(1'b1, 32'h3128FFFF, 32'h00400008); step();
        chk("andi.arith", arith, 1'b0);
        chk("andi.opcode", opcode, 6'h0C);
        drive(1'b1, 32'h3C081234, 32'h0040000C); step();
        chk("lui.arith", arith, 1'b0);
        chk("lui.rt", rt, 5'd8);
        chk("lui.imm", imm, 16'h1234);
        drive(1'b1, 32'h8D28FFFC, 32'h00400010); step();
        chk("lw.arith", arith, 1'b1);
        chk("lw.imm", imm, 16'hFFFC);
        chk("lw.opcode", opcode, 6'h23);
        drive(1'b1, 32'h34000001, 32'h00400014); step();
        chk("ori.arith", arith, 1'b0);
        drive(1'b1, 32'h38000001, 32'h00400018); step();
        chk("xori.arith", arith, 1'b0);
        drive(1'b1, 32'h2C000001, 32'h0040001C); step();
        chk("sltiu.arith", arith, 1'b1);
        drive(1'b1, 32'h40000001, 32'h00400020); step();
        chk("op10.arith", arith, 1'b1);

        // sll $t0,$t1,4 and j, plus PC value at the wrap point
        drive(1'b1, 32'h00094100, 32'hFFFFFFFC); step();
        chk("sll.rt", rt, 5'd9);
        chk("sll.rd", rd, 5'd8);
        chk("sll.shamt", shamt, 5'd4);
        chk("sll.pc", pc_plus4_out, 32'hFFFFFFFC);
        drive(1'b1, 32'h08100004, 32'h00000000); step();
        chk("j.opcode", opcode, 6'h02);
        chk("j.target", jump_target, 26'h0100004);

        // add, then stall three cycles with a new instruction on the input
        drive(1'b1, 32'h012A4020, 32'h00400030); step();
        chk_all("add", 32'h012A4020, 32'h00400030, 1'b1, 1'b1);
        chk("add.rd", rd, 5'd8);
        chk("add.funct", funct, 6'h20);
        stall = 1'b1;
        drive(1'b1, 32'h2128FFFF, 32'h00400034);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("stall", 32'h012A4020, 32'h00400030, 1'b1, 1'b1);
        end
        stall = 1'b0;
        step();
        chk_all("unstall", 32'h2128FFFF, 32'h00400034, 1'b1, 1'b1);

        // flush beats stall
        flush = 1'b1; stall = 1'b1;
        step();
        chk_all("flush+stall", 32'h0, 32'h0, 1'b0, 1'b1);
        flush = 1'b0; stall = 1'b1;
        step();
        chk_all("stall.empty", 32'h0, 32'h0, 1'b0, 1'b1);
        stall = 1'b0;
        drive(1'b1, 32'h3128FFFF, 32'h00400040); step();
        chk_all("reload", 32'h3128FFFF, 32'h00400040, 1'b1, 1'b0);
        flush = 1'b1;
        step();
        chk_all("flush", 32'h0, 32'h0, 1'b0, 1'b1);
        flush = 1'b0;

        // Bubble with an undefined instruction word
        drive(1'b1, 32'h3C081234, 32'h00400050); step();
        drive(1'b0, 32'hxxxxxxxx, 32'hxxxxxxxx); step();
        chk_all("bubble", 32'h0, 32'h0, 1'b0, 1'b1);
        chk("bubble.fieldsX", $isunknown({opcode, rs, rt, rd, shamt, funct, imm, jump_target}), 1'b0);

        // Reset during a stall
        drive(1'b1, 32'h3128FFFF, 32'h00400060); step();
        stall = 1'b1;
        drive(1'b1, 32'h2128FFFF, 32'h00400064); step();
        chk_all("hold.andi", 32'h3128FFFF, 32'h00400060, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        chk_all("reset.stall", 32'h0, 32'h0, 1'b0, 1'b1);
        reset = 1'b0; stall = 1'b0;
        step();
        chk_all("post.reset", 32'h2128FFFF, 32'h00400064, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
